// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction/memory handshake and control-word bundle for multicycle_control
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3
);
    logic [OPCODE_W-1:0] Inst_31_26;
    logic                Mem_Ready;
    logic                PC_Write;
    logic                PC_Write_Cond;
    logic                PC_Write_Not_Equal;
    logic                IorD;
    logic                IR_Write;
    logic                Mem_Read;
    logic                Mem_Write;
    logic [1:0]          Reg_Dst;
    logic [1:0]          Mem_to_Reg;
    logic                Reg_Write;
    logic                ALU_Src_A;
    logic [1:0]          ALU_Src_B;
    logic [ALU_OP_W-1:0] ALU_Op;
    logic [1:0]          PC_Source;
    logic                Instr_Done;
    logic                Illegal_Op;
    logic [3:0]          State;

    modport master (
        input  Inst_31_26, Mem_Ready,
        output PC_Write, PC_Write_Cond, PC_Write_Not_Equal, IorD, IR_Write,
               Mem_Read, Mem_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A,
               ALU_Src_B, ALU_Op, PC_Source, Instr_Done, Illegal_Op, State
    );

    modport slave (
        output Inst_31_26, Mem_Ready,
        input  PC_Write, PC_Write_Cond, PC_Write_Not_Equal, IorD, IR_Write,
               Mem_Read, Mem_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A,
               ALU_Src_B, ALU_Op, PC_Source, Instr_Done, Illegal_Op, State
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM; MULTICYCLE_CONTROL_JAL_EN enables jal
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(15);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_FN  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_LUI = 3'b111;

    // Pure state-decoded part of the control word; handshake-qualified strobes are added at the outputs.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                fetch_ready;
    logic                illegal;

    function automatic state_t dispatch(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE:                                      return S_EXEC_R;
            OP_LW, OP_SW:                                  return S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI,
            OP_LUI:                                        return S_EXEC_I;
            OP_BEQ, OP_BNE:                                return S_BRANCH;
            OP_J:                                          return S_JUMP;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            OP_JAL:                                        return S_JUMP;
`endif
            default:                                       return S_FETCH;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            OP_XORI: return ALU_XOR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic ctrl_t moore_decode(input state_t s, input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = ALU_ADD; end
            S_DECODE:    begin c.alu_src_b = 2'b11; c.alu_op = ALU_ADD; end
            S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
            S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.instr_done = 1'b1; end
            S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_op = ALU_FN; end
            S_EXEC_I:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = imm_alu_op(op); end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = (op == OP_RTYPE) ? 2'b01 : 2'b00;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_source     = 2'b01;
                c.pc_write_cond = (op == OP_BEQ);
                c.pc_write_ne   = (op == OP_BNE);
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                if (op == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b10;
                end
`endif
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH:     if (bus.Mem_Ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = bus.Inst_31_26;
                state_d  = dispatch(bus.Inst_31_26);
            end
            S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.Mem_Ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.Mem_Ready) state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:    state_d = S_ALU_WB;
            default:     state_d = S_FETCH;
        endcase
        // Registering the decode of the next state keeps outputs glitch-free yet aligned with state_q.
        ctrl_d = moore_decode(state_d, opcode_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            ctrl_q   <= moore_decode(S_FETCH, '0);
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign fetch_ready = (state_q == S_FETCH) && bus.Mem_Ready;
    assign illegal     = ((state_q == S_DECODE) && (dispatch(bus.Inst_31_26) == S_FETCH)) ||
                         (state_q > S_JUMP);

    assign bus.PC_Write           = !reset && (ctrl_q.pc_write || fetch_ready);
    assign bus.PC_Write_Cond      = !reset && ctrl_q.pc_write_cond;
    assign bus.PC_Write_Not_Equal = !reset && ctrl_q.pc_write_ne;
    assign bus.IorD               = !reset && ctrl_q.iord;
    assign bus.IR_Write           = !reset && fetch_ready;
    assign bus.Mem_Read           = !reset && ctrl_q.mem_read;
    assign bus.Mem_Write          = !reset && ctrl_q.mem_write;
    assign bus.Reg_Dst            = reset ? 2'b00 : ctrl_q.reg_dst;
    assign bus.Mem_to_Reg         = reset ? 2'b00 : ctrl_q.mem_to_reg;
    assign bus.Reg_Write          = !reset && ctrl_q.reg_write;
    assign bus.ALU_Src_A          = !reset && ctrl_q.alu_src_a;
    assign bus.ALU_Src_B          = reset ? 2'b00 : ctrl_q.alu_src_b;
    assign bus.ALU_Op             = reset ? '0 : ALU_OP_W'(ctrl_q.alu_op);
    assign bus.PC_Source          = reset ? 2'b00 : ctrl_q.pc_source;
    assign bus.Instr_Done         = !reset && (ctrl_q.instr_done ||
                                               ((state_q == S_MEM_WRITE) && bus.Mem_Ready));
    assign bus.Illegal_Op         = !reset && illegal;
    assign bus.State              = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against an instruction-level model
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(6), .ALU_OP_W(3)) bus ();
    multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int path[5];
    int path_n;

    function automatic bit is_legal(input int op);
        case (op)
            0, 2, 4, 5, 8, 10, 12, 13, 14, 15, 35, 43: return 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            3: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu(input int op);
        case (op)
            12: return 3'b011;
            13: return 3'b100;
            10: return 3'b101;
            14: return 3'b110;
            15: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Control word the specification's per-state table demands, packed in a fixed field order.
    function automatic logic [21:0] expect_outs(input int st, input int op, input bit rdy);
        logic pcw, pcc, pcne, iord, irw, mr, mw, rw, sa, done, ill;
        logic [1:0] rd, mtr, sb, pcs;
        logic [2:0] alu;
        {pcw, pcc, pcne, iord, irw, mr, mw, rw, sa, done, ill} = '0;
        {rd, mtr, sb, pcs, alu} = '0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; ill = !is_legal(op); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; mtr = 2'b01; done = 1; end
            5:  begin mw = 1; iord = 1; done = rdy; end
            6:  begin sa = 1; alu = 3'b010; end
            7:  begin sa = 1; sb = 2'b10; alu = imm_alu(op); end
            8:  begin rw = 1; rd = (op == 0) ? 2'b01 : 2'b00; done = 1; end
            9:  begin sa = 1; alu = 3'b001; pcs = 2'b01; pcc = (op == 4); pcne = (op == 5); done = 1; end
            10: begin
                pcw = 1; pcs = 2'b10; done = 1;
                if (op == 3) begin rw = 1; rd = 2'b10; mtr = 2'b10; end
            end
            default: ;
        endcase
        return {pcw, pcc, pcne, iord, irw, mr, mw, rd, mtr, rw, sa, sb, alu, pcs, done, ill};
    endfunction

    function automatic logic [21:0] actual_outs();
        return {bus.PC_Write, bus.PC_Write_Cond, bus.PC_Write_Not_Equal, bus.IorD, bus.IR_Write,
                bus.Mem_Read, bus.Mem_Write, bus.Reg_Dst, bus.Mem_to_Reg, bus.Reg_Write,
                bus.ALU_Src_A, bus.ALU_Src_B, bus.ALU_Op, bus.PC_Source, bus.Instr_Done,
                bus.Illegal_Op};
    endfunction

    task automatic build_path(input int op);
        path[0] = 0; path[1] = 1; path_n = 2;
        if (op == 0)                      begin path[2] = 6; path[3] = 8; path_n = 4; end
        else if (op == 35)                begin path[2] = 2; path[3] = 3; path[4] = 4; path_n = 5; end
        else if (op == 43)                begin path[2] = 2; path[3] = 5; path_n = 4; end
        else if (op == 4 || op == 5)      begin path[2] = 9; path_n = 3; end
        else if (op == 2 || (op == 3 && is_legal(3))) begin path[2] = 10; path_n = 3; end
        else if (is_legal(op))            begin path[2] = 7; path[3] = 8; path_n = 4; end
    endtask

    task automatic check_cycle(input int st, input int op, input bit rdy, input string tag);
        logic [21:0] exp_o;
        exp_o = expect_outs(st, op, rdy);
        @(negedge clk);
        checks++;
        assert (bus.State === 4'(st)) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.State, st);
        end
        checks++;
        assert (actual_outs() === exp_o) else begin
            errors++;
            $error("FAIL %s outs(st%0d): observed %h expected %h", tag, st, actual_outs(), exp_o);
        end
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH to its last state; memory states stall by count or at random.
    task automatic run_instr(input int op, input int stall, input bit rnd, input string tag);
        int idx, waits, st;
        bit rdy, mem;
        build_path(op);
        idx = 0; waits = 0;
        while (idx < path_n) begin
            st = path[idx];
            mem = (st == 0 || st == 3 || st == 5);
            bus.Inst_31_26 = (st <= 1) ? 6'(op) : 6'($urandom);
            rdy = 1'b1;
            if (mem) begin
                if (rnd && waits < 6) rdy = ($urandom_range(0, 3) != 0);
                else if (!rnd && st != 0 && waits < stall) rdy = 1'b0;
            end
            bus.Mem_Ready = rdy;
            check_cycle(st, op, rdy, tag);
            if (rdy || !mem) begin idx++; waits = 0; end
            else waits++;
        end
    endtask

    int op_list[13] = '{0, 35, 43, 8, 12, 13, 10, 14, 15, 4, 5, 2, 3};

    initial begin
        int op;
        reset = 1'b1;
        bus.Mem_Ready = 1'b0;
        bus.Inst_31_26 = 6'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.Mem_Ready = 1'(i[0]);
            @(negedge clk);
            checks++;
            assert (bus.State === 4'd0) else begin
                errors++; $error("FAIL reset_state: observed %0d expected 0", bus.State);
            end
            checks++;
            assert (actual_outs() === 22'd0) else begin
                errors++; $error("FAIL reset_outs: observed %h expected 0", actual_outs());
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;

        run_instr(0, 0, 0, "r_type");
        run_instr(35, 2, 0, "lw_stall");
        run_instr(5, 0, 0, "bne");
        run_instr(4, 0, 0, "beq");
        run_instr(63, 0, 0, "illegal63");
        run_instr(3, 0, 0, "jal");
        run_instr(2, 0, 0, "j");
        run_instr(43, 1, 0, "sw_stall");
        for (int i = 3; i <= 8; i++) run_instr(op_list[i], 0, 0, "itype");

        // Reset arriving while a store is stalled waiting on memory.
        bus.Inst_31_26 = 6'd43;
        bus.Mem_Ready = 1'b1;
        check_cycle(0, 43, 1'b1, "rst_sw");
        check_cycle(1, 43, 1'b1, "rst_sw");
        bus.Inst_31_26 = 6'd0;
        check_cycle(2, 43, 1'b1, "rst_sw");
        bus.Mem_Ready = 1'b0;
        check_cycle(5, 43, 1'b0, "rst_sw");
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        assert (bus.State === 4'd0 && bus.Mem_Write === 1'b0) else begin
            errors++;
            $error("FAIL rst_mid_sw: observed state %0d mem_write %b expected 0 0", bus.State, bus.Mem_Write);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(0, 0, 0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            op = op_list[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) == 0) op = int'($urandom_range(0, 63));
            run_instr(op, 0, 1'b1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
